// File: rtl/sm4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sm4_pkg
//  Description : Shared constants, state type and helper functions for the
//                SM4 key-expansion stage (FK, CK, L' transform, rotate).
//  Revision    : 1.0  initial release
// ============================================================================
package sm4_pkg;

    localparam int SM4_ROUNDS = 32;

    // Two-state controller; RUN is what o_busy reports
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } kex_state_e;

    // System parameter FK, word 0 first
    localparam logic [31:0] FK [4] = '{
        32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC
    };

    // Fixed parameter CK_i; byte j = (4i+j)*7 mod 256, MSB byte first
    localparam logic [31:0] CK [SM4_ROUNDS] = '{
        32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
        32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
        32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
        32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
        32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
        32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
        32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
        32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
    };

    function automatic logic [31:0] ROL32(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Key-schedule linear transform L'(B) = B ^ (B<<<13) ^ (B<<<23)
    function automatic logic [31:0] L_KEY(input logic [31:0] b);
        return b ^ ROL32(b, 13) ^ ROL32(b, 23);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sm4_ck_rom.sv
`default_nettype none
// ============================================================================
//  Module      : sm4_ck_rom
//  Description : Combinational lookup of the SM4 round constant CK_i.
//  Revision    : 1.0  initial release
// ============================================================================
module sm4_ck_rom (
    input  logic [4:0]  i_idx,
    output logic [31:0] o_ck
);

    // Round index to CK_i constant
    always_comb begin
        o_ck = '0;
        case (i_idx)
            5'd0:  o_ck = 32'h00070e15;
            5'd1:  o_ck = 32'h1c232a31;
            5'd2:  o_ck = 32'h383f464d;
            5'd3:  o_ck = 32'h545b6269;
            5'd4:  o_ck = 32'h70777e85;
            5'd5:  o_ck = 32'h8c939aa1;
            5'd6:  o_ck = 32'ha8afb6bd;
            5'd7:  o_ck = 32'hc4cbd2d9;
            5'd8:  o_ck = 32'he0e7eef5;
            5'd9:  o_ck = 32'hfc030a11;
            5'd10: o_ck = 32'h181f262d;
            5'd11: o_ck = 32'h343b4249;
            5'd12: o_ck = 32'h50575e65;
            5'd13: o_ck = 32'h6c737a81;
            5'd14: o_ck = 32'h888f969d;
            5'd15: o_ck = 32'ha4abb2b9;
            5'd16: o_ck = 32'hc0c7ced5;
            5'd17: o_ck = 32'hdce3eaf1;
            5'd18: o_ck = 32'hf8ff060d;
            5'd19: o_ck = 32'h141b2229;
            5'd20: o_ck = 32'h30373e45;
            5'd21: o_ck = 32'h4c535a61;
            5'd22: o_ck = 32'h686f767d;
            5'd23: o_ck = 32'h848b9299;
            5'd24: o_ck = 32'ha0a7aeb5;
            5'd25: o_ck = 32'hbcc3cad1;
            5'd26: o_ck = 32'hd8dfe6ed;
            5'd27: o_ck = 32'hf4fb0209;
            5'd28: o_ck = 32'h10171e25;
            5'd29: o_ck = 32'h2c333a41;
            5'd30: o_ck = 32'h484f565d;
            5'd31: o_ck = 32'h646b7279;
            default: o_ck = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sm4_kex.sv
`default_nettype none
// ============================================================================
//  Module      : sm4_kex
//  Description : SM4 key expansion, one round per clock, external S-box.
//                Emits rk0..rk31 (encryption order) on a 1024-bit bus.
//                Optional macro SM4_KEX_ZEROIZE_EN adds a synchronous
//                i_zeroize that wipes all key material.
//  Revision    : 1.0  initial release
// ============================================================================
module sm4_kex
    import sm4_pkg::*;
#(
    parameter int DLY = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
`ifdef SM4_KEX_ZEROIZE_EN
    input  logic          i_zeroize,
`endif
    input  logic [127:0]  i_key,
    input  logic          i_key_en,
    output logic [1023:0] o_keyex,
    output logic          o_keyex_ok,
    output logic          o_busy,
    output logic [31:0]   o_sbox_din,
    input  logic [31:0]   i_sbox_dout
);

    localparam logic [4:0] c_LAST_RND = 5'(SM4_ROUNDS - 1);

    kex_state_e    r_state;
    logic [4:0]    r_cnt;
    logic [31:0]   r_k [4];
    logic [1023:0] r_keyex;
    logic          r_ok;

    logic [4:0]    w_rnd;
    logic [31:0]   w_k0, w_k1, w_k2, w_k3;
    logic [31:0]   w_ck;
    logic [31:0]   w_rk;
    logic [9:0]    w_lsb;
    logic          w_active;
    logic          w_clr;

    // DLY only annotates delay-aware simulation netlists; these registers use zero-delay updates
    if (DLY < 0) begin : g_dly_range
    end

`ifdef SM4_KEX_ZEROIZE_EN
    assign w_clr = i_zeroize;
`else
    assign w_clr = 1'b0;
`endif

    // A strobe starts round 0 straight from the key input, otherwise use the K window
    always_comb begin
        w_rnd = r_cnt;
        w_k0  = r_k[0];
        w_k1  = r_k[1];
        w_k2  = r_k[2];
        w_k3  = r_k[3];
        if (i_key_en) begin
            w_rnd = 5'd0;
            w_k0  = i_key[127:96] ^ FK[0];
            w_k1  = i_key[95:64]  ^ FK[1];
            w_k2  = i_key[63:32]  ^ FK[2];
            w_k3  = i_key[31:0]   ^ FK[3];
        end
    end

    sm4_ck_rom u_ck_rom (
        .i_idx (w_rnd),
        .o_ck  (w_ck)
    );

    assign w_active   = i_key_en | (r_state == ST_RUN);
    // S-box input is held at zero while idle to keep the shared S-box quiet
    assign o_sbox_din = w_active ? (w_k1 ^ w_k2 ^ w_k3 ^ w_ck) : 32'h0;
    assign w_rk       = w_k0 ^ L_KEY(i_sbox_dout);
    // rk_i lives at bits [1023-32i -: 32], i.e. LSB at 992-32i
    assign w_lsb      = 10'd992 - {w_rnd, 5'b00000};

    // Round controller: load/restart, step through 32 rounds, then hold
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_k[0]  <= '0;
            r_k[1]  <= '0;
            r_k[2]  <= '0;
            r_k[3]  <= '0;
            r_keyex <= '0;
            r_ok    <= 1'b0;
        end else if (w_clr) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_k[0]  <= '0;
            r_k[1]  <= '0;
            r_k[2]  <= '0;
            r_k[3]  <= '0;
            r_keyex <= '0;
            r_ok    <= 1'b0;
        end else if (w_active) begin
            r_keyex[w_lsb +: 32] <= w_rk;
            r_k[0] <= w_k1;
            r_k[1] <= w_k2;
            r_k[2] <= w_k3;
            r_k[3] <= w_rk;
            if (i_key_en) begin
                r_cnt   <= 5'd1;
                r_state <= ST_RUN;
                r_ok    <= 1'b0;
            end else begin
                // Counter wraps from the last round back to zero
                r_cnt <= r_cnt + 5'd1;
                if (r_cnt == c_LAST_RND) begin
                    r_state <= ST_IDLE;
                    r_ok    <= 1'b1;
                end
            end
        end
    end

    assign o_keyex    = r_keyex;
    assign o_keyex_ok = r_ok;
    assign o_busy     = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_sm4_kex.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sm4_kex
//  Description : Self-checking bench for sm4_kex with an S-box model and a
//                behavioural key-schedule reference.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sm4_kex;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          key_en = 1'b0;
    logic          zeroize = 1'b0;
    logic [127:0]  key = '0;
    logic [1023:0] keyex;
    logic          ok, busy;
    logic [31:0]   sbox_din, sbox_dout;

    always #5 clk = ~clk;

    localparam logic [7:0] SBOX [256] = '{
        8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
        8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
        8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
        8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
        8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
        8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
        8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
        8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
        8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
        8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
        8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
        8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
        8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
        8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
        8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
        8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
    };

    // External combinational S-box, four bytes in parallel
    assign sbox_dout = {SBOX[sbox_din[31:24]], SBOX[sbox_din[23:16]],
                        SBOX[sbox_din[15:8]],  SBOX[sbox_din[7:0]]};

    sm4_kex #(.DLY(1)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
`ifdef SM4_KEX_ZEROIZE_EN
        .i_zeroize   (zeroize),
`endif
        .i_key       (key),
        .i_key_en    (key_en),
        .o_keyex     (keyex),
        .o_keyex_ok  (ok),
        .o_busy      (busy),
        .o_sbox_din  (sbox_din),
        .i_sbox_dout (sbox_dout)
    );

    // ---------------- reference model ----------------
    localparam logic [127:0] FK_ALL = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] x);
        return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    endfunction

    function automatic logic [31:0] ck(input int i);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
        return r;
    endfunction

    function automatic logic [1023:0] sched(input logic [127:0] mk);
        logic [31:0]   k [36];
        logic [127:0]  s;
        logic [31:0]   t;
        logic [1023:0] r;
        s = mk ^ FK_ALL;
        for (int i = 0; i < 4; i++) k[i] = s[127-32*i -: 32];
        for (int i = 0; i < 32; i++) begin
            t = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck(i));
            k[i+4] = k[i] ^ t ^ rol(t, 13) ^ rol(t, 23);
            r[1023-32*i -: 32] = k[i+4];
        end
        return r;
    endfunction

    function automatic logic [31:0] din0(input logic [127:0] mk);
        logic [127:0] s;
        s = mk ^ FK_ALL;
        return s[95:64] ^ s[63:32] ^ s[31:0] ^ ck(0);
    endfunction

    function automatic logic [127:0] encrypt(input logic [1023:0] rks, input logic [127:0] pt);
        logic [31:0] x [36];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) x[i] = pt[127-32*i -: 32];
        for (int i = 0; i < 32; i++) begin
            t = tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ rks[1023-32*i -: 32]);
            x[i+4] = x[i] ^ t ^ rol(t, 2) ^ rol(t, 10) ^ rol(t, 18) ^ rol(t, 24);
        end
        return {x[35], x[34], x[33], x[32]};
    endfunction

    // ---------------- checking ----------------
    int checks = 0;
    int failures = 0;

    // Rounds completed since the last strobe (0 = never, 32 = schedule valid)
    int            m_done = 0;
    logic [1023:0] m_sched = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_bus(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        bit shown;
        checks++;
        shown = 1'b0;
        if (act !== exp) begin
            failures++;
            for (int i = 0; i < 32; i++) begin
                if (!shown && act[1023-32*i -: 32] !== exp[1023-32*i -: 32]) begin
                    $display("FAIL %s rk%0d actual=%h required=%h", name, i,
                             act[1023-32*i -: 32], exp[1023-32*i -: 32]);
                    shown = 1'b1;
                end
            end
        end
    endtask

    // One clock cycle: drive, check outputs mid-cycle, advance the model at the edge
    task automatic step(input logic en, input logic [127:0] k);
        key_en = en;
        key    = k;
        @(negedge clk);
        chk("keyex_ok", 128'(ok), 128'(m_done == 32));
        chk("busy", 128'(busy), 128'(m_done >= 1 && m_done < 32));
        if (m_done == 32) chk_bus("keyex", keyex, m_sched);
        if (en) chk("sbox_din_round0", 128'(sbox_din), 128'(din0(k)));
        else if (m_done == 0 || m_done == 32) chk("sbox_din_idle", 128'(sbox_din), 128'h0);
        @(posedge clk);
        if (en) begin
            m_done  = 1;
            m_sched = sched(k);
        end else if (m_done >= 1 && m_done < 32) begin
            m_done++;
        end
        #1;
        key_en = 1'b0;
    endtask

    typedef struct {
        logic [127:0] key;
        logic [31:0]  rk0;
        logic [31:0]  rk1;
        logic [31:0]  rk31;
    } vec_t;

    vec_t          tbl [4];
    logic [1023:0] held;
    logic [127:0]  rk_tmp;

    initial begin
        // Known-answer entry plus random keys with model-derived expectations
        tbl[0] = '{128'h0123456789ABCDEFFEDCBA9876543210, 32'hF12186F9, 32'h41662B61, 32'h9124A012};
        for (int i = 1; i < 4; i++) begin
            rk_tmp = {$urandom, $urandom, $urandom, $urandom};
            held   = sched(rk_tmp);
            tbl[i] = '{rk_tmp, held[1023:992], held[991:960], held[31:0]};
        end

        // Reset state
        #12;
        chk("rst_keyex", 128'(keyex != '0), 128'h0);
        chk("rst_ok", 128'(ok), 128'h0);
        chk("rst_busy", 128'(busy), 128'h0);
        chk("rst_sbox_din", 128'(sbox_din), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) step(1'b0, '0);

        // Table-driven schedules; ok must rise exactly 32 clocks after the strobe
        for (int v = 0; v < 4; v++) begin
            step(1'b1, tbl[v].key);
            repeat (31) step(1'b0, '0);
            chk("vec_ok", 128'(ok), 128'h1);
            chk("vec_rk0", 128'(keyex[1023:992]), 128'(tbl[v].rk0));
            chk("vec_rk1", 128'(keyex[991:960]), 128'(tbl[v].rk1));
            chk("vec_rk31", 128'(keyex[31:0]), 128'(tbl[v].rk31));
            if (v == 0)
                chk("ciphertext", encrypt(keyex, 128'h0123456789ABCDEFFEDCBA9876543210),
                    128'h681EDF34D206965E86B3E94F536E4246);
            step(1'b0, '0);
        end

        // Restart at cycle 10 of RUN with the all-zero key
        step(1'b1, tbl[1].key);
        repeat (9) step(1'b0, '0);
        step(1'b1, 128'h0);
        repeat (31) step(1'b0, '0);
        chk("restart_ok", 128'(ok), 128'h1);
        chk_bus("restart_keyex", keyex, sched(128'h0));

        // Back-to-back strobes: completion counts from the last one
        step(1'b1, tbl[2].key);
        step(1'b1, tbl[3].key);
        step(1'b1, tbl[0].key);
        repeat (32) step(1'b0, '0);

        // Idle hold after completion
        held = keyex;
        repeat (100) step(1'b0, '0);
        chk_bus("idle_hold", keyex, held);

        // Asynchronous reset at cycle 20 of RUN
        step(1'b1, tbl[3].key);
        repeat (19) step(1'b0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_keyex", 128'(keyex != '0), 128'h0);
        chk("areset_ok", 128'(ok), 128'h0);
        chk("areset_busy", 128'(busy), 128'h0);
        chk("areset_sbox_din", 128'(sbox_din), 128'h0);
        m_done = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (40) step(1'b0, '0);

`ifdef SM4_KEX_ZEROIZE_EN
        // Zeroize wins over a simultaneous strobe
        step(1'b1, tbl[0].key);
        repeat (31) step(1'b0, '0);
        zeroize = 1'b1;
        key_en  = 1'b1;
        key     = tbl[1].key;
        @(posedge clk);
        #1;
        zeroize = 1'b0;
        key_en  = 1'b0;
        chk("zeroize_keyex", 128'(keyex != '0), 128'h0);
        chk("zeroize_ok", 128'(ok), 128'h0);
        chk("zeroize_busy", 128'(busy), 128'h0);
        m_done = 0;
        repeat (5) step(1'b0, '0);
`endif

        // Randomized strobes and keys against the model
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 39) == 0, {$urandom, $urandom, $urandom, $urandom});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound
    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
